// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x-oversampled UART receiver with majority voting, error checks and a small result FIFO
module uart_rx_oversample #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       break_det,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(OVERSAMPLE);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PH_A = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_B = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_C = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [PW-1:0] PH_L = PW'(OVERSAMPLE - 1);
    localparam logic          PODD = 1'(PARITY_ODD);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    logic          rx_m, rx_s, rx_prev;
    logic [DW-1:0] div_cnt;
    logic [PW-1:0] phase;
    logic          s_a, s_b;
    logic [2:0]    state, bit_cnt;
    logic [7:0]    shreg;
    logic          pe_r;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [9:0]    head;
    logic          tick, start, dec, maj, push, pop, full, wr_en;

    assign tick  = div_cnt == DW'(DIV - 1);
    assign start = state == IDLE && rx_prev && !rx_s;
    assign dec   = tick && phase == PH_C && state != IDLE;
    assign maj   = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
    assign push  = dec && state == STOP && (maj || shreg != 8'd0);
    assign full  = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign pop   = rx_valid && rx_ready;
    assign wr_en = push && (!full || pop);
    assign head  = mem[rd_ptr[AW-1:0]];

    assign rx_valid   = wr_ptr != rd_ptr;
    assign rx_data    = rx_valid ? head[9:2] : 8'd0;
    assign frame_err  = rx_valid && head[1];
    assign parity_err = rx_valid && head[0];
    assign busy       = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            div_cnt <= '0;
            phase   <= '0;
            s_a     <= 1'b1;
            s_b     <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            phase   <= start ? '0 : tick ? (phase == PH_L ? '0 : phase + 1'b1) : phase;
            s_a     <= tick && phase == PH_A ? rx_s : s_a;
            s_b     <= tick && phase == PH_B ? rx_s : s_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            pe_r      <= 1'b0;
            break_det <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            break_det <= dec && state == STOP && !maj && shreg == 8'd0;
            overrun   <= push && full && !pop;
            case (state)
                IDLE: if (start) state <= START;
                START: if (dec) begin
                    state   <= maj ? IDLE : DATA;
                    bit_cnt <= '0;
                    pe_r    <= 1'b0;
                end
                DATA: if (dec) begin
                    shreg   <= {maj, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state <= PARITY_EN != 0 ? PARITY : STOP;
                end
                PARITY: if (dec) begin
                    pe_r  <= (^shreg ^ maj) != PODD;
                    state <= STOP;
                end
                STOP: if (dec) state <= maj ? IDLE : WAIT_IDLE;
                WAIT_IDLE: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // storage needs no reset: the read side is masked by rx_valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {shreg, !maj, pe_r};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
        end
    end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed checks of the oversampling UART receiver (8N1 and 8E1 instances)
module tb_uart_rx_oversample;
    logic       clk = 1'b0, rst = 1'b1;
    logic       rx = 1'b1, rx_ready = 1'b0, rx_p = 1'b1, rx_ready_p = 1'b0;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, frame_err, parity_err, break_det, overrun, busy;
    logic       rx_valid_p, frame_err_p, parity_err_p, break_det_p, overrun_p, busy_p;
    int         checks = 0, errors = 0, n_brk = 0, n_ovr = 0, n_vcyc = 0;
    logic [9:0] pop_q[$];

    localparam int BIT = 432;

    uart_rx_oversample u_dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
        .break_det(break_det), .overrun(overrun), .busy(busy)
    );

    uart_rx_oversample #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .rst(rst), .rx(rx_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
        .rx_ready(rx_ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p),
        .break_det(break_det_p), .overrun(overrun_p), .busy(busy_p)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) pop_q.push_back({rx_data, frame_err, parity_err});
        if (rx_valid) n_vcyc++;
        if (break_det) n_brk++;
        if (overrun) n_ovr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic b);
        if (sel) rx_p = b;
        else rx = b;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit par_en, input logic par, input logic stop);
        drive(sel, 1'b0);
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_clk(BIT);
        end
        if (par_en) begin
            drive(sel, par);
            wait_clk(BIT);
        end
        drive(sel, stop);
        wait_clk(BIT);
        drive(sel, 1'b1);
    endtask

    function automatic logic [9:0] popped(input int k);
        return pop_q.size() > k ? pop_q[k] : 10'h3ff;
    endfunction

    initial begin
        logic [7:0] b3c;
        wait_clk(5);
        chk("reset_outputs", {rx_valid, busy, break_det, overrun, frame_err, parity_err, rx_data}, 0);
        chk("reset_outputs_p", {rx_valid_p, busy_p, break_det_p, overrun_p, frame_err_p, parity_err_p, rx_data_p}, 0);
        rst = 1'b0;
        wait_clk(5);

        rx_ready = 1'b1;
        send(0, 8'hA5, 0, 1'b0, 1'b1);
        wait_clk(20);
        chk("t1_pop_count", pop_q.size(), 1);
        chk("t1_entry", popped(0), {8'hA5, 2'b00});
        chk("t1_valid_cycles", n_vcyc, 1);
        chk("t1_busy", busy, 0);

        rx = 1'b0;
        wait_clk(100);
        chk("t2_busy_in_glitch", busy, 1);
        wait_clk(116);
        rx = 1'b1;
        wait_clk(600);
        chk("t2_busy_after", busy, 0);
        chk("t2_no_push", pop_q.size(), 1);
        chk("t2_valid", rx_valid, 0);

        send(1, 8'h03, 1, 1'b1, 1'b1);
        wait_clk(20);
        chk("t3_parity_bad", {rx_valid_p, rx_data_p, frame_err_p, parity_err_p}, {1'b1, 8'h03, 1'b0, 1'b1});
        rx_ready_p = 1'b1;
        wait_clk(1);
        rx_ready_p = 1'b0;
        chk("t3_popped", rx_valid_p, 0);
        send(1, 8'h03, 1, 1'b0, 1'b1);
        wait_clk(20);
        chk("t3_parity_ok", {rx_valid_p, rx_data_p, frame_err_p, parity_err_p}, {1'b1, 8'h03, 1'b0, 1'b0});

        send(0, 8'h55, 0, 1'b0, 1'b0);
        wait_clk(20);
        chk("t4_pop_count", pop_q.size(), 2);
        chk("t4_frame_err", popped(1), {8'h55, 2'b10});
        wait_clk(BIT);
        rx = 1'b0;
        wait_clk(20 * BIT);
        chk("t4_wait_idle_busy", busy, 1);
        chk("t4_break_pulses", n_brk, 1);
        chk("t4_break_no_push", pop_q.size(), 2);
        rx = 1'b1;
        wait_clk(BIT);
        chk("t4_idle_after_break", busy, 0);
        chk("t4_break_once", n_brk, 1);

        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send(0, 8'(k), 0, 1'b0, 1'b1);
        wait_clk(20);
        chk("t5_overrun", n_ovr, 1);
        chk("t5_head", {rx_valid, rx_data}, {1'b1, 8'h01});
        rx_ready = 1'b1;
        wait_clk(10);
        chk("t5_pop_count", pop_q.size(), 6);
        for (int k = 0; k < 4; k++) chk($sformatf("t5_order_%0d", k), popped(2 + k), {8'(k + 1), 2'b00});
        chk("t5_drained", rx_valid, 0);

        rx_ready = 1'b0;
        send(0, 8'h11, 0, 1'b0, 1'b1);
        send(0, 8'h22, 0, 1'b0, 1'b1);
        wait_clk(20);
        chk("t6_queued", {rx_valid, rx_data}, {1'b1, 8'h11});
        b3c = 8'h3C;
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b3c[i];
            wait_clk(BIT);
        end
        rx = b3c[4];
        wait_clk(200);
        chk("t6_busy_mid_frame", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_reset_clears", {rx_valid, busy}, 0);
        wait_clk(3);
        rst = 1'b0;
        rx = 1'b1;
        wait_clk(2 * BIT);
        chk("t6_after_reset", {rx_valid, busy}, 0);
        rx_ready = 1'b1;
        send(0, 8'hC3, 0, 1'b0, 1'b1);
        wait_clk(20);
        chk("t6_pop_count", pop_q.size(), 7);
        chk("t6_entry", popped(6), {8'hC3, 2'b00});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
